// File: rtl/qcldpc_syndrome_checker.sv
// qcldpc_syndrome_checker: streaming QC-LDPC syndrome check, XOR-accumulating circulant-rotated blocks per parity row
module qcldpc_syndrome_checker #(
  parameter int NUM_Z = 3,
  parameter int MAX_Z = 81,
  parameter int NUM_INFO_BLKS = 20,
  parameter int NUM_PARITY_BLKS = 4,
  parameter int Z_VALUES [NUM_Z] = '{27, 54, 81},
  localparam int TOTAL_BLKS = NUM_INFO_BLKS + NUM_PARITY_BLKS,
  localparam int SHW = $clog2(MAX_Z),
  localparam int AW = $clog2(NUM_Z * TOTAL_BLKS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_Z-1:0]                   req_z,
  input  logic [MAX_Z-1:0]                   blk_in,
  input  logic                               blk_valid,
  output logic                               blk_ready,
  output logic [AW-1:0]                      rom_addr,
  input  logic [NUM_PARITY_BLKS*SHW-1:0]     rom_shift,
  input  logic [NUM_PARITY_BLKS-1:0]         rom_null,
  output logic [NUM_PARITY_BLKS*MAX_Z-1:0]   syndrome,
  output logic                               syn_valid,
  output logic                               syn_pass,
  output logic                               err_cfg
);
  localparam int ZW = NUM_Z > 1 ? $clog2(NUM_Z) : 1;
  localparam int CW = TOTAL_BLKS > 1 ? $clog2(TOTAL_BLKS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [ZW-1:0] z_idx, z_in;
  logic [MAX_Z-1:0] blk_q;
  logic pend, start, accept, last;
  logic [NUM_PARITY_BLKS-1:0][MAX_Z-1:0] acc, rot;

  // rotate left within the low z bits; bits at or above z are dropped on both sides
  function automatic logic [MAX_Z-1:0] rotl(input logic [MAX_Z-1:0] d, input logic [SHW-1:0] s, input int z);
    logic [MAX_Z-1:0] m;
    logic [2*MAX_Z-1:0] w;
    for (int i = 0; i < MAX_Z; i++) m[i] = i < z;
    w = {{MAX_Z{1'b0}}, d & m} << (int'(s) % z);
    w = w | (w >> z);
    return w[MAX_Z-1:0] & m;
  endfunction

  always_comb begin
    z_in = '0;
    for (int k = 0; k < NUM_Z; k++) if (req_z[k]) z_in = ZW'(k);
  end

  assign last = col == CW'(TOTAL_BLKS - 1);
  assign start = blk_valid & blk_ready & (state == IDLE) & $onehot(req_z);
  assign accept = start | (blk_valid & blk_ready & (state == RUN));
  assign rom_addr = AW'((state == IDLE ? z_in : z_idx) * TOTAL_BLKS + int'(col));

  always_comb begin
    rot = '0;
    for (int r = 0; r < NUM_PARITY_BLKS; r++)
      for (int k = 0; k < NUM_Z; k++)
        if (z_idx == ZW'(k)) rot[r] = rotl(blk_q, rom_shift[r*SHW +: SHW], Z_VALUES[k]);
  end

  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = TOTAL_BLKS == 1 ? FLUSH : RUN;
      RUN:     if (accept && last) state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb blk_ready = rst_n & (state == IDLE | state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      z_idx <= '0;
      blk_q <= '0;
      pend <= 1'b0;
      acc <= '0;
      syndrome <= '0;
      syn_pass <= 1'b0;
      syn_valid <= 1'b0;
      err_cfg <= 1'b0;
    end else begin
      pend <= accept;
      err_cfg <= blk_valid & blk_ready & (state == IDLE) & !$onehot(req_z);
      syn_valid <= state == DONE;
      if (accept) begin
        blk_q <= blk_in;
        col <= last ? '0 : col + 1'b1;
      end
      if (start) z_idx <= z_in;
      // the ROM answers one cycle after rom_addr, so the accumulate trails the accepted beat
      for (int r = 0; r < NUM_PARITY_BLKS; r++)
        acc[r] <= start ? '0 : (pend && !rom_null[r]) ? acc[r] ^ rot[r] : acc[r];
      if (state == DONE) begin
        syndrome <= acc;
        syn_pass <= ~|acc;
      end
    end
  end
endmodule
